// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ENTRY_W    = 64;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } fetch_state_e;

  // One buffered fetch: byte PC plus the instruction word read at that PC
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} entries ahead of decode.
// Ports: Clk/Rst (async active-low), push/pop/flush controls,
//        dataIn (tail write), dataOut (head entry), count (0..2).
// Flush wins over push/pop. The caller never pushes into a full buffer
// unless it also pops in the same cycle.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         Clk,
  input  logic         Rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t dataIn,
  output fetch_entry_t dataOut,
  output logic [1:0]   count
);

  fetch_entry_t slot_q [2];
  logic [1:0]   count_q;

  // Slot 0 is always the head; a pop shifts slot 1 down
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      count_q   <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot_q[0] <= dataIn;
          else                 slot_q[1] <= dataIn;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          slot_q[0] <= slot_q[1];
          count_q   <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains
          if (count_q == 2'd1) begin
            slot_q[0] <= dataIn;
          end else begin
            slot_q[0] <= slot_q[1];
            slot_q[1] <= dataIn;
          end
        end
        default: ;
      endcase
    end
  end

  assign dataOut = slot_q[0];
  assign count   = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, drives the word address of a
// combinational instruction memory, buffers returned words in a 2-entry
// skid buffer and hands them to decode with valid/ready.
// Ports: Clk, Rst (async active-low); imemAddr/imemData memory side;
//        redirectValid/redirectTarget branch redirect; haltIn sticky halt;
//        decodeReady/fetchValid/fetchInstr/fetchPC/fetchPCPlus4 decode side;
//        fault (sticky illegal target / fetch past end); fetchCount.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  input  logic        haltIn,
  input  logic        decodeReady,
  output logic        fetchValid,
  output logic [31:0] fetchInstr,
  output logic [31:0] fetchPC,
  output logic [31:0] fetchPCPlus4,
  output logic        fault,
  output logic [31:0] fetchCount
);

  localparam logic [31:0] DEPTH_LIMIT = 32'(IMEM_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         fault_q, fault_d;

  logic         push_c, pop_c, flush_c, buf_pop_c;
  logic         target_bad_c, pc_oob_c;
  logic [1:0]   buf_count;
  fetch_entry_t head, tail_in;

  assign target_bad_c = (redirectTarget[1:0] != 2'b00) ||
                        ((redirectTarget >> 2) >= DEPTH_LIMIT);
  assign pc_oob_c     = (pc_q >> 2) >= DEPTH_LIMIT;
  assign pop_c        = fetchValid & decodeReady;
  assign buf_pop_c    = pop_c & ~flush_c;
  assign tail_in      = '{pc: pc_q, instr: imemData};

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  // Next state: redirect beats halt beats sequential fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    fault_d = fault_q;
    push_c  = 1'b0;
    flush_c = 1'b0;
    if (state_q == ST_RUN) begin
      if (redirectValid) begin
        flush_c = 1'b1;
        if (target_bad_c) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          pc_d = redirectTarget;
          if (haltIn) state_d = ST_HALTED;
        end
      end else if (haltIn) begin
        state_d = ST_HALTED;
      end else if (pc_oob_c) begin
        // Ran off the end of memory; no wrap
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else if ((buf_count != 2'd2) || pop_c) begin
        push_c  = 1'b1;
        pc_d    = pc_q + 32'(WORD_BYTES);
        count_d = count_q + 32'd1;
      end
    end
  end

  fetch_skid_buffer u_buf (
    .Clk    (Clk),
    .Rst    (Rst),
    .push   (push_c),
    .pop    (buf_pop_c),
    .flush  (flush_c),
    .dataIn (tail_in),
    .dataOut(head),
    .count  (buf_count)
  );

  // Head fields read as zero whenever nothing is valid
  assign fetchValid   = buf_count != 2'd0;
  assign fetchInstr   = fetchValid ? head.instr : 32'd0;
  assign fetchPC      = fetchValid ? head.pc : 32'd0;
  assign fetchPCPlus4 = fetchValid ? head.pc + 32'(WORD_BYTES) : 32'd0;
  assign imemAddr     = {2'b00, pc_q[31:2]};
  assign fault        = fault_q;
  assign fetchCount   = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; memory word k holds 0x1357_0000 + k.
module tb_fetch_controller;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = 32'd0;
  logic        haltIn = 1'b0;
  logic        decodeReady = 1'b0;
  logic        fetchValid;
  logic [31:0] fetchInstr;
  logic [31:0] fetchPC;
  logic [31:0] fetchPCPlus4;
  logic        fault;
  logic [31:0] fetchCount;

  logic [31:0] mem [1024];
  int errors = 0;
  int checks = 0;

  fetch_controller #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(1024)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .imemAddr      (imemAddr),
    .imemData      (imemData),
    .redirectValid (redirectValid),
    .redirectTarget(redirectTarget),
    .haltIn        (haltIn),
    .decodeReady   (decodeReady),
    .fetchValid    (fetchValid),
    .fetchInstr    (fetchInstr),
    .fetchPC       (fetchPC),
    .fetchPCPlus4  (fetchPCPlus4),
    .fault         (fault),
    .fetchCount    (fetchCount)
  );

  always #5 Clk = ~Clk;

  always_comb imemData = (imemAddr < 32'd1024) ? mem[imemAddr[9:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    redirectValid  = 1'b0;
    redirectTarget = 32'd0;
    haltIn         = 1'b0;
    Rst            = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1357_0000 + 32'(i);

    // Reset values
    decodeReady = 1'b1;
    #12;
    chk("rst_valid", 32'(fetchValid), 32'd0);
    chk("rst_instr", fetchInstr, 32'd0);
    chk("rst_pc", fetchPC, 32'd0);
    chk("rst_pc4", fetchPCPlus4, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_count", fetchCount, 32'd0);
    chk("rst_addr", imemAddr, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // Streaming A,B,C,D at one per cycle
    step();
    chk("s0_valid", 32'(fetchValid), 32'd1);
    chk("s0_instr", fetchInstr, 32'h1357_0000);
    chk("s0_pc", fetchPC, 32'h0);
    chk("s0_pc4", fetchPCPlus4, 32'h4);
    chk("s0_addr", imemAddr, 32'd1);
    step();
    chk("s1_instr", fetchInstr, 32'h1357_0001);
    chk("s1_pc", fetchPC, 32'h4);
    step();
    chk("s2_instr", fetchInstr, 32'h1357_0002);
    chk("s2_pc", fetchPC, 32'h8);
    step();
    chk("s3_instr", fetchInstr, 32'h1357_0003);
    chk("s3_pc", fetchPC, 32'hC);
    chk("s3_count", fetchCount, 32'd4);

    // Backpressure: buffer fills to 2 and PC freezes
    do_reset();
    decodeReady = 1'b1;
    step();
    decodeReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_instr", fetchInstr, 32'h1357_0000);
      chk("bp_addr", imemAddr, 32'd2);
    end
    chk("bp_count", fetchCount, 32'd2);
    decodeReady = 1'b1;
    step();
    chk("bp_r1_instr", fetchInstr, 32'h1357_0001);
    chk("bp_r1_pc", fetchPC, 32'h4);
    step();
    chk("bp_r2_instr", fetchInstr, 32'h1357_0002);
    chk("bp_r2_count", fetchCount, 32'd4);
    step();
    chk("bp_r3_instr", fetchInstr, 32'h1357_0003);
    chk("bp_r3_count", fetchCount, 32'd5);

    // Redirect to 0x40 with two entries buffered
    decodeReady    = 1'b0;
    redirectValid  = 1'b1;
    redirectTarget = 32'h40;
    step();
    chk("rd_valid", 32'(fetchValid), 32'd0);
    chk("rd_addr", imemAddr, 32'h10);
    chk("rd_count", fetchCount, 32'd5);
    redirectValid = 1'b0;
    decodeReady   = 1'b1;
    step();
    chk("rd_t_valid", 32'(fetchValid), 32'd1);
    chk("rd_t_instr", fetchInstr, 32'h1357_0010);
    chk("rd_t_pc", fetchPC, 32'h40);
    chk("rd_t_pc4", fetchPCPlus4, 32'h44);
    step();
    chk("rd_t1_instr", fetchInstr, 32'h1357_0011);
    chk("rd_t1_pc", fetchPC, 32'h44);

    // Misaligned target faults and sticks
    do_reset();
    step();
    redirectValid  = 1'b1;
    redirectTarget = 32'h42;
    step();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_valid", 32'(fetchValid), 32'd0);
    chk("mis_count", fetchCount, 32'd1);
    chk("mis_addr", imemAddr, 32'd1);
    redirectValid = 1'b0;
    repeat (3) step();
    chk("mis_fault_hold", 32'(fault), 32'd1);
    chk("mis_valid_hold", 32'(fetchValid), 32'd0);
    chk("mis_count_hold", fetchCount, 32'd1);
    Rst = 1'b0;
    #1;
    chk("mis_fault_clr", 32'(fault), 32'd0);

    // Out-of-range target faults and sticks
    do_reset();
    step();
    redirectValid  = 1'b1;
    redirectTarget = 32'h1000;
    step();
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_valid", 32'(fetchValid), 32'd0);
    redirectValid = 1'b0;
    repeat (3) step();
    chk("oor_fault_hold", 32'(fault), 32'd1);
    chk("oor_count_hold", fetchCount, 32'd1);

    // Last legal word, then sequential fetch runs off the end
    do_reset();
    step();
    redirectValid  = 1'b1;
    redirectTarget = 32'hFFC;
    step();
    chk("last_valid0", 32'(fetchValid), 32'd0);
    chk("last_fault0", 32'(fault), 32'd0);
    chk("last_addr", imemAddr, 32'h3FF);
    redirectValid = 1'b0;
    step();
    chk("last_instr", fetchInstr, 32'h1357_03FF);
    chk("last_pc", fetchPC, 32'hFFC);
    chk("last_pc4", fetchPCPlus4, 32'h1000);
    chk("last_count", fetchCount, 32'd2);
    step();
    chk("end_fault", 32'(fault), 32'd1);
    chk("end_valid", 32'(fetchValid), 32'd0);
    chk("end_count", fetchCount, 32'd2);

    // Halt together with redirect: target never fetched
    do_reset();
    step();
    haltIn         = 1'b1;
    redirectValid  = 1'b1;
    redirectTarget = 32'h20;
    step();
    chk("hr_valid", 32'(fetchValid), 32'd0);
    chk("hr_addr", imemAddr, 32'd8);
    haltIn        = 1'b0;
    redirectValid = 1'b0;
    repeat (4) step();
    chk("hr_valid_hold", 32'(fetchValid), 32'd0);
    chk("hr_fault", 32'(fault), 32'd0);
    chk("hr_count", fetchCount, 32'd1);
    chk("hr_addr_hold", imemAddr, 32'd8);

    // Halt lets buffered entries drain
    do_reset();
    step();
    decodeReady = 1'b0;
    step();
    haltIn = 1'b1;
    step();
    chk("hd_instr", fetchInstr, 32'h1357_0000);
    chk("hd_count", fetchCount, 32'd2);
    haltIn      = 1'b0;
    decodeReady = 1'b1;
    step();
    chk("hd_drain_instr", fetchInstr, 32'h1357_0001);
    chk("hd_drain_pc", fetchPC, 32'h4);
    step();
    chk("hd_empty", 32'(fetchValid), 32'd0);
    chk("hd_count_final", fetchCount, 32'd2);

    // Asynchronous reset mid-stream with a full buffer
    do_reset();
    step();
    decodeReady = 1'b0;
    step();
    chk("ar_pre_valid", 32'(fetchValid), 32'd1);
    Rst = 1'b0;
    #1;
    chk("ar_valid", 32'(fetchValid), 32'd0);
    chk("ar_count", fetchCount, 32'd0);
    chk("ar_addr", imemAddr, 32'd0);
    chk("ar_instr", fetchInstr, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    step();
    chk("ar_restart_instr", fetchInstr, 32'h1357_0000);
    chk("ar_restart_count", fetchCount, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the word-indexed instruction memory: owns the program counter and drives the memory's word address.
- Captures each returned instruction with its PC into a 2-entry skid buffer and presents it to decode with a valid/ready handshake.
- Handles branch/jump redirect with flush, halt, and a fault on illegal targets.
- Sits between the instruction memory (combinational read, word index in, 32-bit word out) and the IF/ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- IMEM_DEPTH, 1024, number of 32-bit words in instruction memory; word index range 0..IMEM_DEPTH-1.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset
- imemAddr  out  32  word index to instruction memory = pcReg >> 2, zero-extended
- imemData  in  32  instruction word returned combinationally for imemAddr
- redirectValid  in  1  branch/jump taken this cycle
- redirectTarget  in  32  byte target address, valid with redirectValid
- haltIn  in  1  stop issuing new fetches; sticky until reset
- decodeReady  in  1  decode accepts the head entry this cycle
- fetchValid  out  1  head entry valid
- fetchInstr  out  32  head instruction
- fetchPC  out  32  byte PC of head instruction
- fetchPCPlus4  out  32  fetchPC + 4, modulo 2^32
- fault  out  1  sticky: illegal redirect target seen
- fetchCount  out  32  instructions pushed into the buffer since reset, wraps

Behaviour:
- Reset (Rst low, asynchronous):
  - pcReg = RESET_PC; buffer count = 0; state = RUN.
  - fetchValid = 0; fetchInstr, fetchPC, fetchPCPlus4, fault and fetchCount all 0.
  - imemAddr = RESET_PC >> 2.
- States:
  - RUN → HALTED on haltIn.
  - RUN → FAULT on an illegal redirect.
  - HALTED and FAULT are left only by reset.
- pop = fetchValid & decodeReady.
- push (RUN, no redirect, not halting, and count < 2 or pop):
  - Write {pcReg, imemData} at the buffer tail.
  - pcReg += 4; fetchCount += 1.
- Latency: an address issued in cycle N appears as head with fetchValid = 1 in cycle N+1 if the buffer was empty. Sustained throughput is 1 instruction/cycle while decodeReady = 1.
- Backpressure:
  - count == 2 with no pop → no push, and pcReg holds.
  - count == 2 with pop → push and pop in the same cycle; count stays 2.
- Output hold: head outputs are stable while fetchValid = 1 and decodeReady = 0.
- Redirect (priority over push and pop):
  - Buffer flushed (count = 0); pcReg = redirectTarget; no push that cycle.
  - fetchValid = 0 in the next cycle. The target instruction is valid two cycles after redirectValid.
- Illegal target: redirectTarget[1:0] != 0, or (redirectTarget >> 2) >= IMEM_DEPTH.
  - State → FAULT; fault = 1; buffer flushed; pcReg holds its old value.
  - No further pushes.
- Halt:
  - haltIn in RUN: no push that cycle or afterwards; state → HALTED.
  - Entries already in the buffer still drain through the handshake.
- Halt and redirect in the same cycle: the redirect is applied (flush, pcReg = target, or FAULT if illegal), then the state becomes HALTED unless it is FAULT. Nothing is fetched from the target.
- Sequential fetch past the last word: when pcReg >> 2 reaches IMEM_DEPTH, the state becomes FAULT and fault = 1. No wrap-around.
- Reset mid-operation: all state is cleared immediately, including buffered entries.
- pcReg wraps modulo 2^32 arithmetically. The range check above makes this unreachable for legal IMEM_DEPTH.

Decomposition:
- Shared package (fetch_pkg):
  - State encoding constants: RUN = 2'd0, HALTED = 2'd1, FAULT = 2'd2.
  - WORD_BYTES = 4.
  - Fetch-entry width (64: PC + instruction).
- Sub-module fetch_skid_buffer: 2-entry FIFO.
  - Ports: push, pop, flush, dataIn, dataOut, count.
  - Shares Clk/Rst.

Test Plan:
- Reset release with RESET_PC = 0, decodeReady = 1, memory words 0..3 = A,B,C,D → fetchValid rises 1 cycle after the first edge. fetchInstr = A,B,C,D on consecutive cycles with fetchPC = 0,4,8,12 and fetchCount = 4.
- decodeReady held 0 for 5 cycles after the first valid → count saturates at 2, imemAddr frozen at 2, fetchInstr stays A. On release, B and C follow with no gaps or duplicates.
- redirectValid with target 0x40 while 2 entries are buffered → next cycle fetchValid = 0. The following cycle fetchInstr = mem[16] with fetchPC = 0x40. The flushed entries never appear.
- redirectTarget = 0x42, and separately 0x1000 with IMEM_DEPTH = 1024 → fault = 1 the next cycle, fetchValid = 0, fetchCount frozen. Both persist until Rst is pulsed low.
- haltIn and redirectValid (target 0x20) in the same cycle → no instruction from 0x20 is ever presented, the state stays HALTED, and fault = 0.
- Rst asserted low mid-stream with count = 2 → fetchValid, count and fetchCount read 0 immediately, before the next clock edge.
